// File: rtl/eth_sw_pkg.sv
// rtl/eth_sw_pkg.sv - shared word/state types for the switch-port packet path
package eth_sw_pkg;
  localparam int ETH_WORD_W = 32;

  typedef struct packed {
    logic                  last;
    logic [ETH_WORD_W-1:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;
endpackage

// File: rtl/eth_tx_fifo.sv
// rtl/eth_tx_fifo.sv - synchronous first-word-fall-through FIFO of {last, data} entries
module eth_tx_fifo
  import eth_sw_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  eth_word_t i_wdata,
  input  logic      i_pop,
  output eth_word_t o_rdata,
  output logic      o_full,
  output logic      o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  eth_word_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/eth_pkt_tx.sv
// rtl/eth_pkt_tx.sv - store-and-forward transmitter onto one switch ingress port
// Buffers whole packets, truncates oversize ones, and emits each packet on contiguous cycles.
module eth_pkt_tx
  import eth_sw_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int MAX_PKT_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ETH_WORD_W-1:0]        in_data,
  input  logic                         in_last,
  input  logic                         stall,
  output logic [ETH_WORD_W-1:0]        out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
  output logic                         oversize_err
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  tx_state_t             r_state;
  logic [ETH_WORD_W-1:0] r_out_data;
  logic                  r_out_sop;
  logic                  r_out_eop;
  logic [PW-1:0]         r_pkt_count;
  logic [CW-1:0]         r_wcnt;
  logic                  r_discard;
  logic                  r_oversize;

  logic      w_full;
  logic      w_empty;
  logic      w_accept;
  logic      w_push;
  logic      w_trunc;
  logic      w_pop;
  eth_word_t w_wr;
  eth_word_t w_head;

  assign in_ready = r_discard || !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && !r_discard;
  assign w_trunc  = w_push && !in_last && (r_wcnt == CW'(MAX_PKT_WORDS - 1));
  assign w_wr     = '{last: in_last || w_trunc, data: in_data};
  // A start needs a complete packet buffered, so SEND never runs dry.
  assign w_pop    = !w_empty && ((r_state == IDLE && r_pkt_count != '0 && !stall)
                                 || r_state == SEND);

  eth_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wr),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wcnt     <= '0;
      r_discard  <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      r_oversize <= w_trunc;
      if (r_discard) begin
        if (w_accept && in_last) r_discard <= 1'b0;
      end else if (w_push) begin
        r_wcnt <= w_wr.last ? '0 : r_wcnt + CW'(1);
        if (w_trunc) r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_push && w_wr.last, w_pop && w_head.last})
        2'b10:   r_pkt_count <= r_pkt_count + PW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - PW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_out_data <= '0;
      r_out_sop  <= 1'b0;
      r_out_eop  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_out_data <= w_head.data;
            r_out_sop  <= 1'b1;
            r_out_eop  <= w_head.last;
            r_state    <= w_head.last ? GAP : SEND;
          end else begin
            r_out_data <= '0;
            r_out_sop  <= 1'b0;
            r_out_eop  <= 1'b0;
          end
        end
        SEND: begin
          r_out_data <= w_head.data;
          r_out_sop  <= 1'b0;
          r_out_eop  <= w_head.last;
          if (w_head.last) r_state <= GAP;
        end
        default: begin
          r_out_data <= '0;
          r_out_sop  <= 1'b0;
          r_out_eop  <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign out_data     = r_out_data;
  assign out_sop      = r_out_sop;
  assign out_eop      = r_out_eop;
  assign pkt_count    = r_pkt_count;
  assign oversize_err = r_oversize;
endmodule

// File: tb/tb_eth_pkt_tx.sv
// tb/tb_eth_pkt_tx.sv - directed self-checking bench for eth_pkt_tx
module tb_eth_pkt_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [4:0]  pkt_count;
  logic        oversize_err;

  int n_pass = 0;
  int n_total = 0;

  eth_pkt_tx #(.DEPTH(16), .MAX_PKT_WORDS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .stall        (stall),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .pkt_count    (pkt_count),
    .oversize_err (oversize_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  logic [33:0] cap[$];
  logic [33:0] exp_w;
  int          ovf_cnt;
  int          ovf_at;
  int          not_ready;
  logic        sop_seen;

  initial begin
    // reset state
    tick(); tick();
    chk("rst_data", out_data, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_cnt", pkt_count, 0);
    chk("rst_ovf", oversize_err, 0);
    reset = 1'b0;
    tick();
    chk("rst_ready", in_ready, 1);

    // 3-word packet
    drive(1, 32'hA1, 0); tick();
    drive(1, 32'hB2, 0); tick();
    drive(1, 32'hC3, 1); tick();
    drive(0, 0, 0);
    chk("p3_cnt1", pkt_count, 1);
    chk("p3_nosop", out_sop, 0);
    tick();
    chk("p3_w0", {out_sop, out_eop, out_data}, {2'b10, 32'hA1});
    chk("p3_cnt_mid", pkt_count, 1);
    tick();
    chk("p3_w1", {out_sop, out_eop, out_data}, {2'b00, 32'hB2});
    tick();
    chk("p3_w2", {out_sop, out_eop, out_data}, {2'b01, 32'hC3});
    chk("p3_cnt0", pkt_count, 0);
    tick();
    chk("p3_quiet", {out_sop, out_eop, out_data}, 34'h0);

    // 1-word packet
    tick();
    drive(1, 32'h55, 1); tick();
    drive(0, 0, 0); tick();
    chk("p1_w0", {out_sop, out_eop, out_data}, {2'b11, 32'h55});
    tick();
    chk("p1_quiet", {out_sop, out_eop, out_data}, 34'h0);

    // two 8-word packets held under stall
    stall = 1'b1;
    sop_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, (i < 8) ? 32'h100 + i : 32'h200 + i - 8, (i % 8) == 7);
      tick();
      sop_seen |= out_sop;
    end
    drive(0, 0, 0);
    chk("st_cnt2", pkt_count, 2);
    chk("st_notready", in_ready, 0);
    chk("st_nosop", sop_seen, 0);
    stall = 1'b0;
    tick();
    chk("st_a0", {out_sop, out_eop, out_data}, {2'b10, 32'h100});
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("st_a", {out_sop, out_eop, out_data}, {1'b0, i == 7, 32'h100 + i});
    end
    tick();
    chk("st_gap", {out_sop, out_eop, out_data}, 34'h0);
    tick();
    chk("st_b0", {out_sop, out_eop, out_data}, {2'b10, 32'h200});
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("st_b", {out_sop, out_eop, out_data}, {1'b0, i == 7, 32'h200 + i});
    end
    tick();

    // stall rising mid-packet
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h31 + i, i == 3);
      tick();
    end
    drive(1, 32'h41, 0); tick();
    chk("ms_w0", {out_sop, out_eop, out_data}, {2'b10, 32'h31});
    drive(1, 32'h42, 1); tick();
    chk("ms_w1", {out_sop, out_eop, out_data}, {2'b00, 32'h32});
    drive(0, 0, 0);
    stall = 1'b1;
    tick();
    chk("ms_w2", {out_sop, out_eop, out_data}, {2'b00, 32'h33});
    tick();
    chk("ms_w3", {out_sop, out_eop, out_data}, {2'b01, 32'h34});
    tick(); tick(); tick();
    chk("ms_held", out_sop, 0);
    chk("ms_cnt", pkt_count, 1);
    stall = 1'b0;
    tick();
    chk("ms_n0", {out_sop, out_eop, out_data}, {2'b10, 32'h41});
    tick();
    chk("ms_n1", {out_sop, out_eop, out_data}, {2'b01, 32'h42});
    tick();

    // oversize packet followed by a short one
    ovf_cnt = 0; ovf_at = -1; not_ready = 0;
    for (int k = 0; k < 30; k++) begin
      if (k < 10)       drive(1, 32'h501 + k, k == 9);
      else if (k < 12)  drive(1, 32'h601 + k - 10, k == 11);
      else              drive(0, 0, 0);
      if (in_valid && !in_ready) not_ready++;
      tick();
      if (oversize_err) begin ovf_cnt++; ovf_at = k; end
      if (out_sop || out_eop || out_data != 0) cap.push_back({out_sop, out_eop, out_data});
    end
    chk("ov_ready", not_ready, 0);
    chk("ov_pulses", ovf_cnt, 1);
    chk("ov_when", ovf_at, 7);
    chk("ov_nwords", cap.size(), 10);
    for (int i = 0; i < 10 && i < cap.size(); i++) begin
      if (i < 8) exp_w = {i == 0, i == 7, 32'h501 + i};
      else       exp_w = {i == 8, i == 9, 32'h601 + i - 8};
      chk("ov_word", cap[i], exp_w);
    end
    chk("ov_cnt0", pkt_count, 0);

    // reset during transmission
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h701 + i, i == 4);
      tick();
    end
    drive(0, 0, 0);
    tick();
    chk("rm_w0", {out_sop, out_eop, out_data}, {2'b10, 32'h701});
    tick();
    chk("rm_w1", {out_sop, out_eop, out_data}, {2'b00, 32'h702});
    reset = 1'b1;
    #1;
    chk("rm_out0", {out_sop, out_eop, out_data}, 34'h0);
    chk("rm_cnt0", pkt_count, 0);
    tick();
    reset = 1'b0;
    chk("rm_ready", in_ready, 1);
    drive(1, 32'h801, 0); tick();
    drive(1, 32'h802, 1); tick();
    drive(0, 0, 0);
    tick();
    chk("rm_n0", {out_sop, out_eop, out_data}, {2'b10, 32'h801});
    tick();
    chk("rm_n1", {out_sop, out_eop, out_data}, {2'b01, 32'h802});
    tick(); tick(); tick();
    chk("rm_stale", {out_sop, out_eop, out_data}, 34'h0);
    chk("rm_cnt_end", pkt_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
